// File: rtl/bin2bcd_seq.sv
// Purpose : sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Latency : start accepted at edge E0, done pulses in the cycle after edge E(WIDTH); WIDTH+2 cycles per conversion.
// Backpr. : no queuing; start is sampled only while idle and ignored while busy or done.
module bin2bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   // Largest representable decimal value must cover the all-ones input.
   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_too_few
      $error("bin2bcd_seq: DIGITS too small to hold the largest WIDTH-bit value");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_bin;
   logic [BW-1:0]      r_scratch;
   logic [BW-1:0]      r_bcd;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;

   logic [BW-1:0]          w_adj;
   logic [BW+WIDTH-1:0]    w_cat;
   logic [BW-1:0]          w_scratch_nxt;
   logic [WIDTH-1:0]       w_bin_nxt;
   logic                   w_last;

   // Add-3 adjust: each digit >= 5 gets +3 within its own nibble, no carry between digits.
   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
         end
      end
   end

   // One shift of the combined {scratch, binary} register; binary MSB enters scratch bit 0.
   assign w_cat         = {w_adj, r_bin} << 1;
   assign w_scratch_nxt = w_cat[BW+WIDTH-1:WIDTH];
   assign w_bin_nxt     = w_cat[WIDTH-1:0];
   assign w_last        = (r_cnt == CW'(1));

   // Control FSM with its datapath registers; busy/done are registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_bin     <= '0;
         r_scratch <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_bin     <= bin;
                  r_scratch <= '0;
                  r_cnt     <= CW'(WIDTH);
                  r_state   <= S_SHIFT;
                  r_busy    <= 1'b1;
               end
            end
            S_SHIFT: begin
               r_scratch <= w_scratch_nxt;
               r_bin     <= w_bin_nxt;
               r_cnt     <= r_cnt - CW'(1);
               if (w_last) begin
                  // Final shift: publish the result at the same edge.
                  r_bcd   <= w_scratch_nxt;
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed conversions, ignored starts, async abort,
// a free-running counter chained into bin, then randomized traffic vs a decimal model.
module tb_bin2bcd_seq;

   localparam int W  = 16;
   localparam int D  = 5;
   localparam int BW = 4 * D;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  bin   = '0;
   logic          busy;
   logic          done;
   logic [BW-1:0] bcd;

   always #5 clk = ~clk;

   bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Decimal reference: plain division, one digit per nibble.
   function automatic logic [BW-1:0] to_bcd(input longint unsigned v);
      logic [BW-1:0] r;
      longint unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic longint unsigned from_bcd(input logic [BW-1:0] b);
      longint unsigned v;
      v = 0;
      for (int i = D - 1; i >= 0; i--) begin
         v = v * 10 + longint'(b[4*i +: 4]);
      end
      return v;
   endfunction

   function automatic bit digits_ok(input logic [BW-1:0] b);
      for (int i = 0; i < D; i++) begin
         if (b[4*i +: 4] > 4'd9) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Behavioural model: cycles of conversion left, done flag, last result.
   int            m_left = 0;
   bit            m_done = 1'b0;
   logic [BW-1:0] m_bcd  = '0;
   logic [W-1:0]  m_val  = '0;

   always @(negedge rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_bcd  = '0;
   end

   always @(posedge clk) begin
      if (rst) begin
         if (m_done) begin
            m_done = 1'b0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_bcd  = to_bcd(longint'(m_val));
            end
         end else if (start) begin
            m_val  = bin;
            m_left = W;
         end
      end
   end

   // Compare process: every cycle, mid-period.
   bit            chk_en   = 1'b0;
   int            done_cnt = 0;
   logic [BW-1:0] done_q[$];

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", longint'(busy), longint'(m_left > 0));
         chk("done", longint'(done), longint'(m_done));
         chk("bcd", longint'(bcd), longint'(m_bcd));
         chk("digits_le_9", longint'(digits_ok(bcd) && digits_ok(dut.r_scratch)), 1);
         if (done) begin
            done_cnt++;
            done_q.push_back(bcd);
         end
      end
   end

   task automatic convert(input logic [W-1:0] v, input logic [BW-1:0] exp, input string nm);
      int nb;
      int lat;
      nb  = 0;
      lat = 0;
      bin   = v;
      start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) begin
            lat = k;
            break;
         end
      end
      chk({nm, "_latency"}, longint'(lat), W + 1);
      chk({nm, "_busy_cycles"}, longint'(nb), W);
      chk(nm, longint'(bcd), longint'(exp));
      @(posedge clk);
      #2;
   endtask

   initial begin
      int d0;
      int q0;
      int wraps;
      int steps_ok;
      logic [W-1:0] cnt;

      #1 rst = 1'b0;
      #11;
      chk("reset_busy", longint'(busy), 0);
      chk("reset_done", longint'(done), 0);
      chk("reset_bcd", longint'(bcd), 0);
      chk("model_12345", longint'(to_bcd(12345)), 64'h12345);
      chk("model_65535", longint'(to_bcd(65535)), 64'h65535);
      chk("model_10", longint'(to_bcd(10)), 64'h10);
      chk_en = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1;

      convert(16'd0,     20'h00000, "conv_0");
      convert(16'hFFFF,  20'h65535, "conv_ffff");
      convert(16'd12345, 20'h12345, "conv_12345");
      convert(16'd9,     20'h00009, "conv_9");
      convert(16'd10,    20'h00010, "conv_10");

      // Second start during SHIFT with a changed bin must be ignored.
      d0    = done_cnt;
      bin   = 16'd999;
      start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      start = 1'b1;
      bin   = 16'd7;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (25) @(posedge clk);
      #2;
      chk("ignored_start_bcd", longint'(bcd), 64'h00999);
      chk("ignored_start_done_count", longint'(done_cnt - d0), 1);

      // Async abort in cycle 8 of a conversion.
      d0    = done_cnt;
      bin   = 16'd54321;
      start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      #1 rst = 1'b0;
      #1;
      chk("abort_busy", longint'(busy), 0);
      chk("abort_done", longint'(done), 0);
      chk("abort_bcd", longint'(bcd), 0);
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (25) @(posedge clk);
      #2;
      chk("abort_no_done", longint'(done_cnt - d0), 0);
      convert(16'd42, 20'h00042, "conv_42_after_abort");

      // Counter chained into bin, start held high, crossing 65535 -> 0.
      q0    = done_q.size();
      cnt   = 16'd65500;
      bin   = cnt;
      start = 1'b1;
      repeat (18 * 8) begin
         @(posedge clk);
         #2;
         cnt = cnt + 16'd1;
         bin = cnt;
      end
      start = 1'b0;
      repeat (25) @(posedge clk);
      #2;
      wraps    = 0;
      steps_ok = 1;
      for (int i = q0; i + 1 < done_q.size(); i++) begin
         if (((from_bcd(done_q[i+1]) + 65536 - from_bcd(done_q[i])) % 65536) != W + 2) steps_ok = 0;
         if (from_bcd(done_q[i+1]) < from_bcd(done_q[i])) wraps++;
      end
      chk("chain_count", longint'(done_q.size() - q0 >= 7), 1);
      chk("chain_step", longint'(steps_ok), 1);
      chk("chain_wrap", longint'(wraps), 1);

      // Randomized traffic, biased toward boundary values.
      d0 = done_cnt;
      repeat (30000) begin
         @(posedge clk);
         #2;
         start = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       bin = '1;
            1:       bin = W'($urandom_range(0, 99));
            default: bin = W'($urandom);
         endcase
      end
      start = 1'b0;
      repeat (25) @(posedge clk);
      #2;
      chk("random_done_seen", longint'(done_cnt - d0 > 1000), 1);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
